// File: rtl/leb128_encoder.sv
// -----------------------------------------------------------------------------
// leb128_encoder
//
// Streaming LEB128 encoder. One WIDTH-bit integer is accepted with a
// signed/unsigned flag. The encoder then emits the minimal-length LEB128 byte
// sequence for it, one byte per out_valid/out_ready handshake.
//
// Configuration macro:
//   LEB128_PAD_EN - adds the in_pad input. The sequence is then padded to
//                   max(minimal length, min(in_pad, MAX_BYTES)) bytes, which
//                   gives a fixed-width immediate that can be patched later.
//                   When the macro is undefined, the encoding is always minimal.
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-low reset
//   in_value   in   WIDTH  integer to encode
//   in_signed  in   1      1: SLEB128, 0: ULEB128
//   in_pad     in   CNT_W  requested minimum length (LEB128_PAD_EN only)
//   in_valid   in   1      in_value/in_signed (and in_pad) valid
//   in_ready   out  1      encoder idle, accepts a value
//   out_byte   out  8      current encoded byte, bit7 = continuation
//   out_valid  out  1      out_byte valid
//   out_ready  in   1      sink accepts out_byte
//   out_last   out  1      out_byte is the final byte of the sequence
//   out_count  out  CNT_W  0-based index of out_byte within the sequence
// -----------------------------------------------------------------------------
module leb128_encoder #(
  parameter int WIDTH = 64,
  localparam int MAX_BYTES = (WIDTH + 6) / 7,
  localparam int CNT_W = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_value,
  input  logic             in_signed,
`ifdef LEB128_PAD_EN
  input  logic [CNT_W-1:0] in_pad,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [CNT_W-1:0] out_count
);

  // The shift register is seven bits wider than the input. This lets the top
  // group always carry the sign or zero extension bits.
  localparam int SR_W = WIDTH + 7;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [SR_W-8:0] UPPER_ZERO = {(SR_W-7){1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for a value
    ST_LOAD = 2'd1,  // value latched, first byte being formed
    ST_EMIT = 2'd2   // presenting bytes to the sink
  } state_t;

  state_t            state_r, state_s;
  logic [SR_W-1:0]   sr_r, sr_s;
  logic              signed_r, signed_s;
  logic [CNT_W-1:0]  pad_r, pad_s;
  logic [CNT_W-1:0]  pad_eff_s;
  logic              in_ready_r, in_ready_s;
  logic [7:0]        out_byte_r, out_byte_s;
  logic              out_valid_r, out_valid_s;
  logic              out_last_r, out_last_s;
  logic [CNT_W-1:0]  out_count_r, out_count_s;
  logic              last_s;
  logic [SR_W-1:0]   ext_s;

  // Drop one LEB128 group. The shift is arithmetic for signed values, so
  // padding bytes of negative values automatically become 0x7F.
  function automatic logic [SR_W-1:0] shift_group(input logic [SR_W-1:0] sr,
                                                  input logic            sgn);
    shift_group = {{7{sgn & sr[SR_W-1]}}, sr[SR_W-1:7]};
  endfunction

  // True when the low group already holds everything that remains. For signed
  // values, bit 6 of the group must also agree with the discarded upper bits.
  function automatic logic is_minimal_end(input logic [SR_W-1:0] sr,
                                          input logic            sgn);
    logic [SR_W-8:0] upper;
    upper = sr[SR_W-1:7];
    if (sgn) begin
      is_minimal_end = ((upper == UPPER_ZERO) && (sr[6] == 1'b0)) ||
                       ((&upper) && (sr[6] == 1'b1));
    end else begin
      is_minimal_end = (upper == UPPER_ZERO);
    end
  endfunction

  // The byte with index cnt is the last byte when the value is exhausted and
  // the requested padding length (capped at MAX_BYTES) has been reached.
  function automatic logic byte_is_last(input logic [SR_W-1:0]  sr,
                                        input logic             sgn,
                                        input logic [CNT_W-1:0] cnt,
                                        input logic [CNT_W-1:0] pad);
    logic [CNT_W-1:0] target;
    logic [CNT_W:0]   produced;
    if (pad > MAX_CNT) begin
      target = MAX_CNT;
    end else begin
      target = pad;
    end
    produced = {1'b0, cnt} + {1'b0, CNT_ONE};
    byte_is_last = is_minimal_end(sr, sgn) && (produced >= {1'b0, target});
  endfunction

`ifdef LEB128_PAD_EN
  assign pad_eff_s = pad_r;
`else
  // A pad target of zero always yields the minimal encoding.
  assign pad_eff_s = CNT_ZERO;
`endif

  // Widen the incoming value. Signed values are sign-extended; unsigned values
  // are zero-extended.
  always_comb begin
    if (in_signed) begin
      ext_s = {{7{in_value[WIDTH-1]}}, in_value};
    end else begin
      ext_s = {7'b0000000, in_value};
    end
  end

  // Next-state and next-output logic of the encoder FSM.
  always_comb begin
    state_s     = state_r;
    sr_s        = sr_r;
    signed_s    = signed_r;
    pad_s       = pad_r;
    in_ready_s  = in_ready_r;
    out_byte_s  = out_byte_r;
    out_valid_s = out_valid_r;
    out_last_s  = out_last_r;
    out_count_s = out_count_r;
    last_s      = 1'b0;

    case (state_r)
      ST_IDLE: begin
        out_valid_s = 1'b0;
        if (in_valid && in_ready_r) begin
          sr_s       = ext_s;
          signed_s   = in_signed;
`ifdef LEB128_PAD_EN
          pad_s      = in_pad;
`else
          pad_s      = CNT_ZERO;
`endif
          in_ready_s = 1'b0;
          state_s    = ST_LOAD;
        end else begin
          in_ready_s = 1'b1;
        end
      end

      ST_LOAD: begin
        last_s      = byte_is_last(sr_r, signed_r, CNT_ZERO, pad_eff_s);
        out_byte_s  = {~last_s, sr_r[6:0]};
        out_last_s  = last_s;
        out_count_s = CNT_ZERO;
        out_valid_s = 1'b1;
        in_ready_s  = 1'b0;
        state_s     = ST_EMIT;
      end

      ST_EMIT: begin
        in_ready_s = 1'b0;
        if (out_valid_r && out_ready) begin
          if (out_last_r) begin
            out_valid_s = 1'b0;
            out_byte_s  = 8'h00;
            out_last_s  = 1'b0;
            out_count_s = CNT_ZERO;
            in_ready_s  = 1'b1;
            state_s     = ST_IDLE;
          end else begin
            // The next byte is formed in the same cycle, so there is no bubble.
            sr_s        = shift_group(sr_r, signed_r);
            out_count_s = out_count_r + CNT_ONE;
            last_s      = byte_is_last(sr_s, signed_r, out_count_s, pad_eff_s);
            out_byte_s  = {~last_s, sr_s[6:0]};
            out_last_s  = last_s;
          end
        end else begin
          // Stalled by the sink: hold all outputs.
          out_valid_s = out_valid_r;
        end
      end

      default: begin
        state_s     = ST_IDLE;
        sr_s        = {SR_W{1'b0}};
        signed_s    = 1'b0;
        pad_s       = CNT_ZERO;
        in_ready_s  = 1'b0;
        out_byte_s  = 8'h00;
        out_valid_s = 1'b0;
        out_last_s  = 1'b0;
        out_count_s = CNT_ZERO;
      end
    endcase
  end

  // State and output registers. Reset clears every register, so an aborted
  // sequence leaves nothing behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      sr_r        <= {SR_W{1'b0}};
      signed_r    <= 1'b0;
      pad_r       <= CNT_ZERO;
      in_ready_r  <= 1'b0;
      out_byte_r  <= 8'h00;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_count_r <= CNT_ZERO;
    end else begin
      state_r     <= state_s;
      sr_r        <= sr_s;
      signed_r    <= signed_s;
      pad_r       <= pad_s;
      in_ready_r  <= in_ready_s;
      out_byte_r  <= out_byte_s;
      out_valid_r <= out_valid_s;
      out_last_r  <= out_last_s;
      out_count_r <= out_count_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_byte  = out_byte_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign out_count = out_count_r;

endmodule

// File: tb/tb_leb128_encoder.sv
module tb_leb128_encoder;
  localparam int WIDTH = 64;
  localparam int MAX_BYTES = 10;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in_value;
  logic             in_signed;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       out_byte;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [CNT_W-1:0] out_count;
`ifdef LEB128_PAD_EN
  logic [CNT_W-1:0] in_pad;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];   // bytes the model still expects
  logic [7:0] rx_q[$];    // bytes actually handed over in the current sequence
  int exp_cnt = 0;        // expected out_count of the head of exp_q

  always #5 clk = ~clk;

  leb128_encoder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_value  (in_value),
    .in_signed (in_signed),
`ifdef LEB128_PAD_EN
    .in_pad    (in_pad),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_count (out_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference encoder: the textbook LEB128 loop on 64-bit integers, followed
  // by padding to the requested length.
  function automatic void model_push(input logic [63:0] v, input logic s, input int pad);
    logic [7:0] seq[$];
    logic [63:0] u;
    longint sv;
    logic [6:0] grp;
    logic fin;
    logic neg;
    logic [7:0] tmp;
    int target;
    neg = s & v[63];
    if (!s) begin
      u = v;
      do begin
        grp = u[6:0];
        u = u >> 7;
        fin = (u == 64'd0);
        seq.push_back({~fin, grp});
      end while (!fin);
    end else begin
      sv = v;
      do begin
        grp = sv[6:0];
        sv = sv >>> 7;
        fin = ((sv == 64'sd0) && !grp[6]) || ((sv == -64'sd1) && grp[6]);
        seq.push_back({~fin, grp});
      end while (!fin);
    end
    target = (pad > MAX_BYTES) ? MAX_BYTES : pad;
    while (seq.size() < target) begin
      tmp = seq.pop_back();
      seq.push_back(tmp | 8'h80);
      seq.push_back(neg ? 8'h7F : 8'h00);
    end
    foreach (seq[i]) exp_q.push_back(seq[i]);
  endfunction

  // Compare process: every cycle with out_valid, check the byte against the model.
  always @(negedge clk) begin
    if (reset && out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 64'(out_valid), 64'd0);
      end else begin
        check("out_byte", 64'(out_byte), 64'(exp_q[0]));
        check("out_last", 64'(out_last), 64'(exp_q.size() == 1));
        check("out_count", 64'(out_count), 64'(exp_cnt));
        if (out_ready) begin
          rx_q.push_back(out_byte);
          void'(exp_q.pop_front());
          exp_cnt++;
        end
      end
    end
  end

  task automatic send(input logic [63:0] v, input logic s, input int pad);
    int guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("accept_ready", 64'(in_ready), 64'd1);
    rx_q.delete();
    exp_cnt = 0;
    model_push(v, s, pad);
    in_value = v;
    in_signed = s;
`ifdef LEB128_PAD_EN
    in_pad = CNT_W'(pad);
`endif
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble the inputs: the encoder must use only the values sampled at accept.
    in_value = 64'hA5A5_5A5A_DEAD_BEEF;
    in_signed = ~s;
  endtask

  task automatic wait_done(input int stall_at, input int stall_n);
    int guard = 0;
    int stalled = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      if (rx_q.size() == stall_at && out_valid && stalled < stall_n) begin
        out_ready = 1'b0;
        stalled++;
      end else begin
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
      guard++;
    end
    out_ready = 1'b1;
    check("drain_complete", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_seq(input string name, input logic [79:0] lit, input int n);
    check({name, "_len"}, 64'(rx_q.size()), 64'(n));
    for (int i = 0; i < n && i < rx_q.size(); i++) begin
      check(name, 64'(rx_q[i]), 64'(lit[8*i +: 8]));
    end
  endtask

  task automatic run(input string name, input logic [63:0] v, input logic s, input int pad,
                     input logic [79:0] lit, input int n, input int stall_at, input int stall_n);
    send(v, s, pad);
    wait_done(stall_at, stall_n);
    if (n > 0) check_seq(name, lit, n);
    check({name, "_idle_ready"}, 64'(in_ready), 64'd1);
    check({name, "_idle_valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    in_value = 64'd0;
    in_signed = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
`ifdef LEB128_PAD_EN
    in_pad = 4'd0;
`endif
    #2;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_byte", 64'(out_byte), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_out_count", 64'(out_count), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rel_in_ready", 64'(in_ready), 64'd1);

    // Single byte: check latency and the return to idle.
    send(64'd2, 1'b0, 0);
    check("t1_ready_drop", 64'(in_ready), 64'd0);
    check("t1_no_valid_yet", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("t1_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    check("t1_ready_back", 64'(in_ready), 64'd1);
    check("t1_valid_off", 64'(out_valid), 64'd0);
    check_seq("u2", 80'h02, 1);

    run("u624485", 64'd624485, 1'b0, 0, 80'h26_8E_E5, 3, -1, 0);
    run("s_m123456", -64'sd123456, 1'b1, 0, 80'h78_BB_C0, 3, -1, 0);
    run("s64", 64'd64, 1'b1, 0, 80'h00_C0, 2, -1, 0);
    run("s_m1", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, 80'h7F, 1, -1, 0);
    run("s_m64", -64'sd64, 1'b1, 0, 80'h40, 1, -1, 0);
    run("u_max", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 80'h01_FF_FF_FF_FF_FF_FF_FF_FF_FF, 10, 4, 3);
    run("s_min", 64'h8000_0000_0000_0000, 1'b1, 0, 80'h7F_80_80_80_80_80_80_80_80_80, 10, 2, 1);
    run("u_top", 64'h8000_0000_0000_0000, 1'b0, 0, 80'h01_80_80_80_80_80_80_80_80_80, 10, -1, 0);
    run("u0", 64'd0, 1'b0, 0, 80'h00, 1, -1, 0);
    run("u128", 64'd128, 1'b0, 0, 80'h01_80, 2, 0, 2);
    run("s63", 64'd63, 1'b1, 0, 80'h3F, 1, -1, 0);
    run("s_m65", -64'sd65, 1'b1, 0, 80'h7F_BF, 2, -1, 0);

    // Abort mid-sequence with reset after two of three bytes.
    send(64'd624485, 1'b0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_rx_count", 64'(rx_q.size()), 64'd2);
    reset = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    #1;
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_ready", 64'(in_ready), 64'd0);
    check("abort_count", 64'(out_count), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_ready_back", 64'(in_ready), 64'd1);
    run("after_abort", 64'd2, 1'b0, 0, 80'h02, 1, -1, 0);

`ifdef LEB128_PAD_EN
    run("p_u2", 64'd2, 1'b0, 5, 80'h00_80_80_80_82, 5, -1, 0);
    run("p_s_m1", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3, 80'h7F_FF_FF, 3, 1, 2);
    run("p1_u624485", 64'd624485, 1'b0, 1, 80'h26_8E_E5, 3, -1, 0);
    run("p2_u624485", 64'd624485, 1'b0, 2, 80'h26_8E_E5, 3, -1, 0);
    run("p12_u2", 64'd2, 1'b0, 12, 80'h00_80_80_80_80_80_80_80_80_82, 10, -1, 0);
    run("p4_s_m64", -64'sd64, 1'b1, 4, 80'h7F_FF_FF_C0, 4, -1, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
